// File: rtl/dma_loader.sv
// Byte-stream DMA front end: decodes a header byte, then writes 1-8 payload bytes
// to the weight memory or the input buffer through single-cycle strobes.
module dma_loader #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ui_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       fetch_w,
  output logic       fetch_i,
  output logic [3:0] dma_address,
  output logic [7:0] dma_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] TGT_NOP     = 2'b00;
  localparam logic [1:0] TGT_WEIGHTS = 2'b01;
  localparam logic [1:0] TGT_INPUTS  = 2'b10;
  localparam logic [1:0] TGT_ILLEGAL = 2'b11;

  state_t     state, state_next;
  logic [1:0] target;
  logic [3:0] addr;
  logic [3:0] remaining;
  logic       err_pend;

  logic       accept;
  logic       last;
  logic [1:0] hdr_target;
  logic [3:0] hdr_len;
  logic [4:0] hdr_end;
  logic       in_bounds;
  logic       hdr_ok;

  assign accept     = in_valid && in_ready;
  assign last       = (remaining == 4'd1);
  assign hdr_target = ui_in[7:6];
  assign hdr_len    = 4'(ui_in[2:0]) + 4'd1;
  // One past the last address written; must not exceed the memory depth.
  assign hdr_end    = 5'(ui_in[5:3]) + 5'(hdr_len);
  assign in_bounds  = (hdr_end <= 5'(DEPTH));
  assign hdr_ok     = in_bounds && (hdr_target == TGT_WEIGHTS || hdr_target == TGT_INPUTS);

  assign in_ready = (state != DONE);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: next state defaults to the current state so no path through the case infers a latch.
    state_next = state;
    case (state)
      IDLE:        if (accept) state_next = hdr_ok ? XFER : DRAIN;
      XFER, DRAIN: if (accept && last) state_next = DONE;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target      <= TGT_NOP;
      addr        <= '0;
      remaining   <= '0;
      err_pend    <= 1'b0;
      err         <= 1'b0;
      fetch_w     <= 1'b0;
      fetch_i     <= 1'b0;
      dma_address <= '0;
      dma_data    <= '0;
    end else begin
      fetch_w <= 1'b0;
      fetch_i <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target    <= hdr_target;
            addr      <= 4'(ui_in[5:3]);
            remaining <= hdr_len;
            err_pend  <= (hdr_target == TGT_ILLEGAL) || !in_bounds;
            err       <= 1'b0;
          end
        end
        XFER: begin
          if (accept) begin
            fetch_w     <= (target == TGT_WEIGHTS);
            fetch_i     <= (target == TGT_INPUTS);
            dma_address <= addr;
            dma_data    <= ui_in;
            addr        <= addr + 4'd1;
            remaining   <= remaining - 4'd1;
          end
        end
        DRAIN: begin
          if (accept) begin
            remaining <= remaining - 4'd1;
            if (last && err_pend) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_loader.sv
// Directed self-checking bench for dma_loader: weight/input loads, stalls,
// bounds and illegal-target errors, NOP drain, boundary write and mid-command reset.
module tb_dma_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ui_in;
  logic       in_valid;
  logic       in_ready;
  logic       fetch_w;
  logic       fetch_i;
  logic [3:0] dma_address;
  logic [7:0] dma_data;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  dma_loader #(.DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ui_in       (ui_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fetch_w     (fetch_w),
    .fetch_i     (fetch_i),
    .dma_address (dma_address),
    .dma_data    (dma_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte across one rising edge, then settle 1 ns after it.
  task automatic drive(input logic v, input logic [7:0] b);
    in_valid = v;
    ui_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input string tag, input logic w, input logic i,
                               input logic [3:0] a, input logic [7:0] d);
    check({tag, ".fetch_w"}, 32'(fetch_w), 32'(w));
    check({tag, ".fetch_i"}, 32'(fetch_i), 32'(i));
    if (w || i) begin
      check({tag, ".addr"}, 32'(dma_address), 32'(a));
      check({tag, ".data"}, 32'(dma_data), 32'(d));
    end
  endtask

  logic [7:0] wdata [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] rdata [3] = '{8'hC1, 8'hC2, 8'hC3};

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    ui_in    = 8'h43;
    #12;
    check("rst.in_ready", 32'(in_ready), 1);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.err", 32'(err), 0);
    check("rst.strobes", 32'({fetch_w, fetch_i}), 0);
    check("rst.addr", 32'(dma_address), 0);
    check("rst.data", 32'(dma_data), 0);
    @(posedge clk);
    #1;
    check("rst.no_accept", 32'(busy), 0);
    reset = 1'b0;
    drive(1'b0, 8'h00);

    // Weight load: 0x43 -> S=0, L=4, continuous
    drive(1'b1, 8'h43);
    check("wl.busy_after_hdr", 32'(busy), 1);
    check("wl.err_after_hdr", 32'(err), 0);
    expect_strobe("wl.hdr", 1'b0, 1'b0, 4'd0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, wdata[k]);
      expect_strobe($sformatf("wl.b%0d", k), 1'b1, 1'b0, 4'(k), wdata[k]);
      check($sformatf("wl.done%0d", k), 32'(done), 32'(k == 3));
    end
    check("wl.in_ready_done", 32'(in_ready), 0);
    check("wl.err", 32'(err), 0);
    drive(1'b0, 8'h00);
    check("wl.idle_busy", 32'(busy), 0);
    check("wl.idle_done", 32'(done), 0);
    expect_strobe("wl.idle", 1'b0, 1'b0, 4'd0, 8'h00);

    // Input load with stalls: 0x89 -> inputs, S=1, L=2
    drive(1'b1, 8'h89);
    drive(1'b0, 8'hEE);
    expect_strobe("il.stall0", 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 8'hA1);
    expect_strobe("il.b0", 1'b0, 1'b1, 4'd1, 8'hA1);
    drive(1'b0, 8'hEE);
    expect_strobe("il.stall1", 1'b0, 1'b0, 4'd0, 8'h00);
    check("il.stall_busy", 32'(busy), 1);
    check("il.stall_done", 32'(done), 0);
    drive(1'b1, 8'hA2);
    expect_strobe("il.b1", 1'b0, 1'b1, 4'd2, 8'hA2);
    check("il.done", 32'(done), 1);
    drive(1'b0, 8'h00);

    // Bounds error: 0x7B -> weights, S=7, L=4 overruns DEPTH
    drive(1'b1, 8'h7B);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'h50 + 8'(k));
      expect_strobe($sformatf("be.b%0d", k), 1'b0, 1'b0, 4'd0, 8'h00);
      check($sformatf("be.done%0d", k), 32'(done), 32'(k == 3));
    end
    check("be.err", 32'(err), 1);
    drive(1'b0, 8'h00);
    check("be.err_sticky", 32'(err), 1);

    // Boundary: 0x78 -> weights, S=7, L=1; header clears err
    drive(1'b1, 8'h78);
    check("bd.err_cleared", 32'(err), 0);
    drive(1'b1, 8'h5A);
    expect_strobe("bd.b0", 1'b1, 1'b0, 4'd7, 8'h5A);
    check("bd.done", 32'(done), 1);
    check("bd.in_ready_low", 32'(in_ready), 0);
    check("bd.in_valid_held", 32'(in_valid), 1);
    drive(1'b1, 8'hC0);
    check("bd.done_no_accept", 32'(busy), 0);
    check("bd.err", 32'(err), 0);

    // Illegal target: 0xC0 -> L=1
    drive(1'b1, 8'hC0);
    check("il_t.busy", 32'(busy), 1);
    drive(1'b1, 8'h99);
    expect_strobe("il_t.b0", 1'b0, 1'b0, 4'd0, 8'h00);
    check("il_t.done", 32'(done), 1);
    check("il_t.err", 32'(err), 1);
    drive(1'b0, 8'h00);

    // NOP: 0x01 -> L=2, consumed silently
    drive(1'b1, 8'h01);
    check("nop.err_cleared", 32'(err), 0);
    drive(1'b1, 8'h61);
    expect_strobe("nop.b0", 1'b0, 1'b0, 4'd0, 8'h00);
    check("nop.done0", 32'(done), 0);
    drive(1'b1, 8'h62);
    expect_strobe("nop.b1", 1'b0, 1'b0, 4'd0, 8'h00);
    check("nop.done1", 32'(done), 1);
    check("nop.err", 32'(err), 0);
    drive(1'b0, 8'h00);

    // Reset mid-XFER of a 4-byte weight command
    drive(1'b1, 8'h43);
    drive(1'b1, 8'hD0);
    drive(1'b1, 8'hD1);
    expect_strobe("rx.pre", 1'b1, 1'b0, 4'd1, 8'hD1);
    #2;
    reset = 1'b1;
    #1;
    check("rx.fetch_w", 32'(fetch_w), 0);
    check("rx.addr", 32'(dma_address), 0);
    check("rx.data", 32'(dma_data), 0);
    check("rx.busy", 32'(busy), 0);
    check("rx.done", 32'(done), 0);
    check("rx.in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    check("rx.in_ready_after", 32'(in_ready), 1);
    check("rx.busy_after", 32'(busy), 0);
    // 0x52 -> weights, S=2, L=3
    drive(1'b1, 8'h52);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, rdata[k]);
      expect_strobe($sformatf("rx.b%0d", k), 1'b1, 1'b0, 4'(2 + k), rdata[k]);
      check($sformatf("rx.done%0d", k), 32'(done), 32'(k == 2));
    end
    drive(1'b0, 8'h00);
    check("rx.final_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
